// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the ALU multiplier and divider.
package fp_pkg;

  localparam int unsigned MANT_W   = 24;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned FRAC_W   = MANT_W - 1;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned EXT_EXP_W = 10;

  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0]  EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_nan(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
    return (e == EXP_MAX) && (f != '0);
  endfunction

  function automatic logic is_inf(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
    return (e == EXP_MAX) && (f == '0);
  endfunction

  // Zero and denormals alike; denormals are flushed.
  function automatic logic is_zero(input logic [EXP_W-1:0] e);
    return e == '0;
  endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential MANT_W x MANT_W shift-add mantissa multiplier; one partial product per cycle.
module shift_add_multiplier
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MANT_W-1:0] mcand,
  input  logic [MANT_W-1:0] mplier,
  output logic              done_c,
  output logic [MANT_W:0]   product
);

  localparam int unsigned PROD_W = 2 * MANT_W;
  localparam int unsigned CNT_W  = $clog2(MANT_W);

  logic              running;
  logic [CNT_W-1:0]  count;
  logic [MANT_W-1:0] mcand_q;
  logic [MANT_W-1:0] mplier_q;
  logic [PROD_W-1:0] acc;

  // Asserted during the final iteration; acc holds the full product one edge later.
  assign done_c  = running && (count == CNT_W'(MANT_W - 1));
  // Only the top MANT_W+1 bits matter to a truncating normaliser.
  assign product = acc[PROD_W-1 -: MANT_W+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      running  <= 1'b0;
      count    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc      <= '0;
    end else if (start) begin
      running  <= 1'b1;
      count    <= '0;
      mcand_q  <= mcand;
      mplier_q <= mplier;
      acc      <= '0;
    end else if (running) begin
      if (mplier_q[0]) begin
        acc <= acc + (PROD_W'(mcand_q) << count);
      end
      mplier_q <= mplier_q >> 1;
      count    <= count + CNT_W'(1);
      if (done_c) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_multiplication.sv
// Multi-cycle IEEE-754 single-precision multiplier with valid/ready on both sides.
module fp_multiplication
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in1,
  input  logic [WORD_W-1:0] in2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out,
  output logic              busy
);

  state_t                 state_q, state_d;
  logic [WORD_W-1:0]      out_d;
  logic                   sign_q, sign_d;
  logic [EXT_EXP_W-1:0]   exp_q, exp_d;
  logic                   start_c;
  logic                   mul_done_c;
  logic [MANT_W:0]        prod_hi;

  logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_in;
  logic signed [EXT_EXP_W-1:0] e_norm;
  logic [FRAC_W-1:0]      frac;

  shift_add_multiplier u_mant (
    .clk     (clk),
    .rst     (rst),
    .start   (start_c),
    .mcand   ({1'b1, in1[FRAC_W-1:0]}),
    .mplier  ({1'b1, in2[FRAC_W-1:0]}),
    .done_c  (mul_done_c),
    .product (prod_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      out       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      out       <= out_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out;
    sign_d  = sign_q;
    exp_d   = exp_q;
    start_c = 1'b0;

    a_nan   = is_nan(in1[30:23], in1[FRAC_W-1:0]);
    b_nan   = is_nan(in2[30:23], in2[FRAC_W-1:0]);
    a_inf   = is_inf(in1[30:23], in1[FRAC_W-1:0]);
    b_inf   = is_inf(in2[30:23], in2[FRAC_W-1:0]);
    a_zero  = is_zero(in1[30:23]);
    b_zero  = is_zero(in2[30:23]);
    sign_in = in1[31] ^ in2[31];

    // Result exponent grows by one when the product mantissa lands in [2,4).
    e_norm  = $signed(exp_q + EXT_EXP_W'(prod_hi[MANT_W]));
    frac    = prod_hi[MANT_W] ? prod_hi[MANT_W-1:1] : prod_hi[MANT_W-2:0];

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = sign_in;
          exp_d  = EXT_EXP_W'(in1[30:23]) + EXT_EXP_W'(in2[30:23]) - EXT_EXP_W'(EXP_BIAS);
          if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
            out_d   = QNAN;
            state_d = DONE;
          end else if (a_inf || b_inf) begin
            out_d   = {sign_in, EXP_MAX, FRAC_W'(0)};
            state_d = DONE;
          end else if (a_zero || b_zero) begin
            out_d   = {sign_in, 31'h0};
            state_d = DONE;
          end else begin
            start_c = 1'b1;
            state_d = MUL;
          end
        end
      end
      MUL: begin
        if (mul_done_c) begin
          state_d = NORM;
        end
      end
      NORM: begin
        if (e_norm >= $signed(EXT_EXP_W'(255))) begin
          out_d = {sign_q, EXP_MAX, FRAC_W'(0)};
        end else if (e_norm <= $signed(EXT_EXP_W'(0))) begin
          out_d = {sign_q, 31'h0};
        end else begin
          out_d = {sign_q, e_norm[EXP_W-1:0], frac};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/fp_multiplication.md
Name: fp_multiplication

Overview:
Multi-cycle IEEE-754 single-precision multiplier. It is the inverse operation of the existing combinational floating-point divider and shares its operand format and truncating mantissa policy. It uses a 24-step shift-add mantissa datapath with a valid/ready handshake on both sides, and sits in the ALU next to the divider so the ALU can sequence mul/div results through one handshake style.

Parameters:
MANT_W, 24, mantissa width including the hidden 1; also the number of shift-add iterations.
EXP_BIAS, 127, exponent bias.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands on in1/in2 are valid.
in_ready  output  1  block can accept operands; high only in IDLE.
in1  input  32  multiplicand, IEEE-754 single.
in2  input  32  multiplier, IEEE-754 single.
out_valid  output  1  result on out is valid; held until accepted.
out_ready  input  1  consumer accepts the result.
out  output  32  product, IEEE-754 single.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, in_ready=1, out_valid=0, out=32'h0, busy=0, iteration counter=0. Reset aborts any operation in progress with no output produced.
- FSM states: IDLE, MUL, NORM, DONE.
- IDLE, accept: in_valid & in_ready at an edge captures the operands.
  - Special operands go straight to DONE with out set at that same edge.
  - Otherwise go to MUL with acc=0, mcand={1,in1[22:0]}, mplier={1,in2[22:0]}, count=0.
- MUL: each cycle, if mplier[0]=1 then acc += mcand<<count. Then mplier>>=1 and count++. After 24 MUL edges (count==23 at the edge), go to NORM. acc is 48 bits.
- NORM, one edge:
  - sign = s1^s2.
  - e = e1 + e2 - EXP_BIAS, computed in 10-bit signed.
  - If acc[47]=1: frac=acc[46:24], e=e+1. Else: frac=acc[45:23].
  - Truncate; no rounding.
  - e>=255 gives a signed infinity {sign,8'hFF,23'h0}. e<=0 gives a signed zero {sign,31'h0}.
  - Register out, go to DONE.
- DONE: out_valid=1 and out held stable. On out_valid & out_ready at an edge: out_valid=0, go to IDLE. in_ready stays 0 until the next cycle, so there is no same-cycle re-accept.
- Latency: accept at edge k gives out_valid visible after edge k+25 for normal operands, and after edge k for specials.
- Special operands, checked in this priority order:
  1. Either operand NaN (exp=FF, frac≠0), or 0×inf in either order, gives 32'h7FC00000.
  2. Either operand inf gives {sign,8'hFF,23'h0}.
  3. Either exp=0 (zero or denormal, denormals flushed) gives {sign,31'h0}.
- in_valid while busy is ignored; the operands are not captured.
- out_ready while out_valid=0 is ignored.
- Operands are not required to stay stable after acceptance.

Decomposition:
- Package fp_pkg: EXP_BIAS, MANT_W, QNAN=32'h7FC00000, EXP_MAX=8'hFF, typedef enum state_t {IDLE,MUL,NORM,DONE}, and a classification helper (is_nan/is_inf/is_zero). The divider reuses the package.
- One sub-module, shift_add_multiplier: a 24x24 sequential mantissa multiplier with start/done and a 48-bit product. It is the counterpart of the divider's mantissa unit. The top level keeps sign/exponent/special-case logic and the handshake FSM.

Test Plan:
1. in1=0x40000000 (2.0), in2=0x40400000 (3.0) -> out=0x40C00000, with out_valid exactly 25 edges after accept.
2. 0x3FC00000 × 0x3FC00000 (1.5×1.5) -> 0x40100000 (normalize path, acc[47]=1). Then 0xC0000000 × 0x3F000000 -> 0xBF800000.
3. 0x00000000 × 0x7F800000 -> 0x7FC00000 one edge after accept. 0x7F800000 × 0xC0000000 -> 0xFF800000. 0x00000001 × 0x3F800000 -> 0x00000000.
4. Overflow: 0x7F000000 × 0x7F000000 -> 0x7F800000. Underflow: 0x00800000 × 0x00800000 -> 0x00000000.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> back to IDLE, next operands accepted the following cycle.
6. Reset mid-MUL (count≈10): rst=1 one cycle -> out_valid=0, in_ready=1, out=0. A subsequent 2.0×3.0 completes correctly.
